// File: rtl/rsa_mont_arbiter.sv
// Two-requester round-robin arbiter in front of a single Montgomery multiplier.
// It runs one operation at a time: latch operands, start, wait for finish, then return the result.
module rsa_mont_arbiter #(
   parameter int DATA_W = 256
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req0,
   input  logic [DATA_W-1:0] i_a0,
   input  logic [DATA_W-1:0] i_b0,
   input  logic              i_req1,
   input  logic [DATA_W-1:0] i_a1,
   input  logic [DATA_W-1:0] i_b1,
   output logic              o_gnt0,
   output logic              o_gnt1,
   output logic              o_done0,
   output logic              o_done1,
   output logic [DATA_W-1:0] o_result,
   output logic              o_busy,
   output logic              o_mont_start,
   output logic [DATA_W-1:0] o_mont_a,
   output logic [DATA_W-1:0] o_mont_b,
   input  logic [DATA_W-1:0] i_mont_result,
   input  logic              i_mont_finish
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_grant_q, last_grant_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic [DATA_W-1:0] mont_a_q, mont_a_d;
   logic [DATA_W-1:0] mont_b_q, mont_b_d;
   logic              sel_s;

   // Next-state logic: arbitration in IDLE, finish capture in WAIT, fairness update in RESP.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      result_d     = result_q;
      mont_a_d     = mont_a_q;
      mont_b_d     = mont_b_q;
      sel_s        = 1'b0;

      // On a tie the requester that did not win last time goes next.
      if (i_req0 && i_req1) begin
         sel_s = ~last_grant_q;
      end else if (i_req1) begin
         sel_s = 1'b1;
      end else begin
         sel_s = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (i_req0 || i_req1) begin
               owner_d  = sel_s;
               mont_a_d = sel_s ? i_a1 : i_a0;
               mont_b_d = sel_s ? i_b1 : i_b0;
               state_d  = S_ISSUE;
            end else begin
               state_d  = S_IDLE;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (i_mont_finish) begin
               result_d = i_mont_result;
               state_d  = S_RESP;
            end else begin
               state_d  = S_WAIT;
            end
         end
         S_RESP: begin
            last_grant_d = owner_q;
            state_d      = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; last_grant resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q      <= S_IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         result_q     <= {DATA_W{1'b0}};
         mont_a_q     <= {DATA_W{1'b0}};
         mont_b_q     <= {DATA_W{1'b0}};
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         result_q     <= result_d;
         mont_a_q     <= mont_a_d;
         mont_b_q     <= mont_b_d;
      end
   end

   assign o_gnt0       = (state_q == S_ISSUE) && (owner_q == 1'b0);
   assign o_gnt1       = (state_q == S_ISSUE) && (owner_q == 1'b1);
   assign o_mont_start = (state_q == S_ISSUE);
   assign o_done0      = (state_q == S_RESP) && (owner_q == 1'b0);
   assign o_done1      = (state_q == S_RESP) && (owner_q == 1'b1);
   assign o_busy       = (state_q != S_IDLE);
   assign o_result     = result_q;
   assign o_mont_a     = mont_a_q;
   assign o_mont_b     = mont_b_q;

endmodule

// File: tb/tb_rsa_mont_arbiter.sv
// Directed bench for rsa_mont_arbiter; the bench itself plays the Montgomery multiplier.
module tb_rsa_mont_arbiter;

   localparam int DW = 256;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req0 = 1'b0, req1 = 1'b0;
   logic [DW-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic          gnt0, gnt1, done0, done1, busy, mstart;
   logic [DW-1:0] result, mont_a, mont_b;
   logic [DW-1:0] mres = '0;
   logic          fin = 1'b0;

   int tests_run = 0;
   int fails = 0;
   int gnt0_cnt = 0;

   rsa_mont_arbiter #(.DATA_W(DW)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req0(req0), .i_a0(a0), .i_b0(b0),
      .i_req1(req1), .i_a1(a1), .i_b1(b1),
      .o_gnt0(gnt0), .o_gnt1(gnt1), .o_done0(done0), .o_done1(done1),
      .o_result(result), .o_busy(busy), .o_mont_start(mstart),
      .o_mont_a(mont_a), .o_mont_b(mont_b),
      .i_mont_result(mres), .i_mont_finish(fin)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (gnt0) gnt0_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req0 = 1'b0; req1 = 1'b0; fin = 1'b0; mres = '0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      rst = 1'b0;
      repeat (2) cycle();
      rst = 1'b1;
      cycle();
   endtask

   task automatic wait_grant(input int budget, output bit found, output int waited);
      found = 1'b0;
      waited = 0;
      while (!found && waited < budget) begin
         cycle();
         waited++;
         if (gnt0 || gnt1) found = 1'b1;
      end
   endtask

   task automatic mult_finish(input logic [DW-1:0] r);
      fin = 1'b1;
      mres = r;
      cycle();
      fin = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #1;
      tests_run++;
      if ({gnt0, gnt1, done0, done1, busy, mstart} !== 6'b0) begin
         fails++; $display("FAIL reset_ctrl: got %b want 000000", {gnt0, gnt1, done0, done1, busy, mstart});
      end
      tests_run++;
      if (result !== '0) begin fails++; $display("FAIL reset_result: got %0h want 0", result); end
      tests_run++;
      if (mont_a !== '0 || mont_b !== '0) begin
         fails++; $display("FAIL reset_operands: got a=%0h b=%0h want 0", mont_a, mont_b);
      end
      do_reset();
   endtask

   task automatic test_single_op();
      do_reset();
      req0 = 1'b1; a0 = 256'd5; b0 = 256'd7;
      cycle();
      tests_run++;
      if ({gnt0, gnt1, mstart, busy} !== 4'b1011) begin
         fails++; $display("FAIL single_grant: got gnt0,gnt1,start,busy=%b want 1011", {gnt0, gnt1, mstart, busy});
      end
      tests_run++;
      if (mont_a !== 256'd5 || mont_b !== 256'd7) begin
         fails++; $display("FAIL single_operands: got a=%0h b=%0h want 5 7", mont_a, mont_b);
      end
      req0 = 1'b0; a0 = 256'd9; b0 = 256'd9;
      repeat (256) cycle();
      tests_run++;
      if (mont_a !== 256'd5 || mont_b !== 256'd7 || mstart !== 1'b0) begin
         fails++; $display("FAIL single_wait_stable: got a=%0h b=%0h start=%b want 5 7 0", mont_a, mont_b, mstart);
      end
      mult_finish(256'h23);
      tests_run++;
      if ({done0, done1} !== 2'b10 || result !== 256'h23) begin
         fails++; $display("FAIL single_done: got done0,done1=%b result=%0h want 10 23", {done0, done1}, result);
      end
      cycle();
      tests_run++;
      if ({done0, busy} !== 2'b00 || result !== 256'h23) begin
         fails++; $display("FAIL single_idle: got done0,busy=%b result=%0h want 00 23", {done0, busy}, result);
      end
   endtask

   task automatic test_round_robin();
      bit found;
      int waited;
      bit exp1;
      do_reset();
      a0 = 256'h100; b0 = 256'h101; a1 = 256'h200; b1 = 256'h201;
      req0 = 1'b1; req1 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp1 = (k % 2) == 1;
         // IDLE follows RESP, so a held request is granted two cycles after its predecessor's done.
         wait_grant(8, found, waited);
         tests_run++;
         if (!found || waited != ((k == 0) ? 1 : 2)) begin
            fails++; $display("FAIL rr_grant_time op%0d: got found=%0d waited=%0d want 1 %0d", k, found, waited, (k == 0) ? 1 : 2);
         end
         tests_run++;
         if ({gnt0, gnt1} !== {~exp1, exp1} || mont_a !== (exp1 ? 256'h200 : 256'h100)) begin
            fails++; $display("FAIL rr_order op%0d: got gnt0,gnt1=%b a=%0h want %b", k, {gnt0, gnt1}, mont_a, {~exp1, exp1});
         end
         cycle();
         mult_finish(256'd1000 + 256'(k));
         tests_run++;
         if ({done0, done1} !== {~exp1, exp1} || result !== 256'd1000 + 256'(k)) begin
            fails++; $display("FAIL rr_done op%0d: got done=%b result=%0d want %b %0d", k, {done0, done1}, result, {~exp1, exp1}, 1000 + k);
         end
      end
      req0 = 1'b0; req1 = 1'b0;
   endtask

   task automatic test_req1_only();
      bit found;
      int waited;
      int g0_start;
      do_reset();
      g0_start = gnt0_cnt;
      req1 = 1'b1; a1 = 256'hABC; b1 = 256'hDEF;
      for (int k = 0; k < 3; k++) begin
         wait_grant(8, found, waited);
         tests_run++;
         if (!found || gnt1 !== 1'b1 || waited != ((k == 0) ? 1 : 2)) begin
            fails++; $display("FAIL r1_grant op%0d: got found=%0d gnt1=%b waited=%0d", k, found, gnt1, waited);
         end
         repeat (3) cycle();
         mult_finish(256'h500 + 256'(k));
         tests_run++;
         if ({done0, done1} !== 2'b01 || result !== 256'h500 + 256'(k)) begin
            fails++; $display("FAIL r1_done op%0d: got done=%b result=%0h", k, {done0, done1}, result);
         end
      end
      req1 = 1'b0;
      cycle();
      tests_run++;
      if (gnt0_cnt != g0_start) begin
         fails++; $display("FAIL r1_no_gnt0: got %0d gnt0 pulses want 0", gnt0_cnt - g0_start);
      end
   endtask

   task automatic test_spurious_finish();
      do_reset();
      mult_finish(256'hDEAD);
      tests_run++;
      if ({done0, done1, busy} !== 3'b000 || result !== '0) begin
         fails++; $display("FAIL spur_idle: got done,busy=%b result=%0h want 000 0", {done0, done1, busy}, result);
      end
      req0 = 1'b1; a0 = 256'd3; b0 = 256'd4;
      cycle();
      tests_run++;
      if (gnt0 !== 1'b1) begin fails++; $display("FAIL spur_grant: got gnt0=%b want 1", gnt0); end
      req0 = 1'b0;
      mult_finish(256'hBEEF);
      repeat (2) cycle();
      tests_run++;
      if ({done0, done1, busy} !== 3'b001 || result !== '0) begin
         fails++; $display("FAIL spur_issue: got done,busy=%b result=%0h want 001 0", {done0, done1, busy}, result);
      end
      mult_finish(256'h55);
      tests_run++;
      if (done0 !== 1'b1 || result !== 256'h55) begin
         fails++; $display("FAIL spur_real: got done0=%b result=%0h want 1 55", done0, result);
      end
   endtask

   task automatic test_reset_mid();
      bit found;
      int waited;
      do_reset();
      req0 = 1'b1; a0 = 256'h77; b0 = 256'h88;
      wait_grant(4, found, waited);
      repeat (2) cycle();
      rst = 1'b0;
      #1;
      tests_run++;
      if ({gnt0, gnt1, done0, done1, busy, mstart} !== 6'b0 || mont_a !== '0 || mont_b !== '0 || result !== '0) begin
         fails++; $display("FAIL midrst_clear: got ctrl=%b a=%0h result=%0h want 0", {gnt0, gnt1, done0, done1, busy, mstart}, mont_a, result);
      end
      req0 = 1'b0;
      cycle();
      rst = 1'b1;
      mult_finish(256'h999);
      tests_run++;
      if ({done0, done1, busy} !== 3'b000 || result !== '0) begin
         fails++; $display("FAIL midrst_late_finish: got done,busy=%b result=%0h want 000 0", {done0, done1, busy}, result);
      end
      req0 = 1'b1; req1 = 1'b1;
      cycle();
      tests_run++;
      if ({gnt0, gnt1} !== 2'b10) begin
         fails++; $display("FAIL midrst_tie: got gnt0,gnt1=%b want 10", {gnt0, gnt1});
      end
      req0 = 1'b0; req1 = 1'b0;
   endtask

   task automatic test_withdraw();
      bit found;
      int waited;
      int g0_start;
      do_reset();
      req1 = 1'b1; a1 = 256'h31; b1 = 256'h32;
      wait_grant(4, found, waited);
      tests_run++;
      if (!found || gnt1 !== 1'b1) begin fails++; $display("FAIL wd_grant1: got found=%0d gnt1=%b want 1 1", found, gnt1); end
      req1 = 1'b0;
      cycle();
      g0_start = gnt0_cnt;
      req0 = 1'b1; a0 = 256'h41;
      repeat (2) cycle();
      req0 = 1'b0;
      mult_finish(256'h99);
      tests_run++;
      if ({done0, done1} !== 2'b01 || result !== 256'h99) begin
         fails++; $display("FAIL wd_done1: got done=%b result=%0h want 01 99", {done0, done1}, result);
      end
      repeat (5) cycle();
      tests_run++;
      if (busy !== 1'b0 || gnt0_cnt != g0_start) begin
         fails++; $display("FAIL wd_no_gnt0: got busy=%b gnt0 pulses=%0d want 0 0", busy, gnt0_cnt - g0_start);
      end
   endtask

   initial begin
      test_reset();
      test_single_op();
      test_round_robin();
      test_req1_only();
      test_spurious_finish();
      test_reset_mid();
      test_withdraw();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
